serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage sitting directly upstream of the 11011 sequence detector.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out one bit per programmable tick.
- Output is a 1-bit stream plus a one-cycle bit_valid strobe; the detector samples the stream.
- Supports gapless back-to-back words, so patterns spanning word boundaries reach the detector intact.

Parameters:
- DATA_W, 8, width of the parallel input word.
- DIV_W, 8, width of the tick-period divider field.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a word this cycle.
- div  input  DIV_W  tick period minus 1; 0 means one bit per clock.
- lsb_first  input  1  1 = shift out LSB first; 0 = MSB first.
- bit_out  output  1  current serial bit; holds between strobes.
- bit_valid  output  1  one-cycle strobe, asserted when bit_out takes a new bit.
- busy  output  1  word in progress (state SHIFT).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; bit_out=0; bit_valid=0; busy=0.
  - Shift register, bit counter and tick counter all cleared.
  - in_ready=1 once reset is released. in_ready is combinational: 1 in IDLE, so it reads 1 while idle.
- Accept: a transfer occurs on a rising edge when in_valid && in_ready. On that edge the block:
  - captures in_data, div and lsb_first into internal registers; changes on these inputs mid-word are ignored;
  - clears the tick and bit counters;
  - enters SHIFT.
- States:
  - IDLE: in_ready=1, busy=0, bit_valid=0. IDLE -> SHIFT on accept.
  - SHIFT: busy=1. The tick counter runs 0..div_latched. On the cycle it equals div_latched (the tick), the next edge:
    - loads bit_out with the current head bit (MSB or LSB per latched lsb_first);
    - pulses bit_valid for one cycle;
    - shifts the register;
    - increments the bit counter;
    - clears the tick counter.
- Latency: the first bit_valid is asserted div+1 cycles after the accept edge. Bits are then spaced exactly div+1 cycles apart.
- Last bit: in_ready=1 in SHIFT only on the tick cycle where bit counter == DATA_W-1.
  - If in_valid is high then, the new word is accepted on the same edge that emits the final bit. State stays SHIFT and the next word's first bit follows div+1 cycles later, so the cadence is unbroken.
  - Otherwise SHIFT -> IDLE on that edge.
- bit_out and bit_valid are registered. bit_valid is never asserted in IDLE except on the edge that emits the last bit (it reads high in the first IDLE cycle).
- in_valid held without an accept (block busy) is not dropped. The word is accepted once in_ready rises.
- div change while in SHIFT has no effect until the next accept.
- Reset mid-word aborts immediately: the remaining bits are discarded and no further bit_valid is produced.
- Width rule: the bit counter is $clog2(DATA_W) bits wide. The tick counter is DIV_W bits and compares for equality with div_latched; no wrap is needed.

Decomposition:
- Shared package serial_feed_pkg holds:
  - state enum {IDLE, SHIFT};
  - DATA_W_DEFAULT and DIV_W_DEFAULT constants.
- One natural sub-module, tick_gen: DIV_W counter with clear, period input and a tick output. The top FSM plus shifter instantiates it.

Test Plan:
- Reset release: in_ready=1, bit_out=0, bit_valid=0, busy=0 for 3 idle cycles with in_valid=0.
- Word 0xDB, div=0, MSB first: bit_valid high 8 consecutive cycles, starting 1 cycle after accept. bit_out sequence 1,1,0,1,1,0,1,1; then busy=0.
- Word 0xDB, div=2, lsb_first=1: strobes every 3rd cycle, first one 3 cycles after accept. bits 1,1,0,1,1,0,1,1, total span 24 cycles.
- Back-to-back 0x1B then 0x60, div=0, in_valid held:
  - the second accept coincides with the first word's 8th bit;
  - 16 consecutive bit_valid cycles with no gap;
  - the stream carries 11011 across the boundary.
- Reset mid-word: assert rst_n=0 after the 3rd bit of 0xFF.
  - Outputs return to reset values immediately and stay there.
  - After release, 0x00 is accepted and emits 8 zeros.
- Mid-word input changes: change div 0->5 and in_data while busy. Cadence and bits follow the latched values; in_ready stays 0 until the last-bit cycle.

Source files
------------

// File: rtl/serial_feed_pkg.sv
// serial_feed_pkg: shared state encoding and default widths for the serial bit feeder
package serial_feed_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  localparam int DATA_W_DEFAULT = 8;
  localparam int DIV_W_DEFAULT  = 8;
endpackage

// File: rtl/serial_bit_feeder_tick_gen.sv
// tick_gen: free-running period counter, pulses tick when count reaches period.
// Ports: clk, rst_n (async low), clr (restart count), en (count while high),
//        period (tick period minus 1), tick (high on the last cycle of each period).
module tick_gen
  import serial_feed_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && (cnt_q == period);
    cnt_d = (clr || !en || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial stage emitting one bit per programmable tick.
// Ports: clk, rst_n (async low); in_data/in_valid/in_ready word handshake;
//        div (tick period minus 1) and lsb_first, both latched on accept;
//        bit_out (held serial bit), bit_valid (one-cycle strobe per new bit), busy (SHIFT).
module serial_bit_feeder
  import serial_feed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIV_W-1:0]  div,
  input  logic              lsb_first,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              lsb_q, lsb_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              tick, last, accept, head;
  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (state_q == SHIFT),
    .period (div_q),
    .tick   (tick)
  );
  // The final bit's tick doubles as an accept slot so back-to-back words keep cadence.
  always_comb begin
    last        = tick && (bit_cnt_q == LAST_BIT);
    in_ready    = (state_q == IDLE) || last;
    accept      = in_valid && in_ready;
    head        = lsb_q ? sr_q[0] : sr_q[DATA_W-1];
    bit_valid_d = tick;
    bit_out_d   = tick ? head : bit_out_q;
    sr_d        = accept ? in_data : tick ? (lsb_q ? sr_q >> 1 : sr_q << 1) : sr_q;
    bit_cnt_d   = accept ? '0 : tick ? bit_cnt_q + 1'b1 : bit_cnt_q;
    div_d       = accept ? div : div_q;
    lsb_d       = accept ? lsb_first : lsb_q;
    state_d     = accept ? SHIFT : last ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      lsb_q       <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      lsb_q       <= lsb_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = (state_q == SHIFT);
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] div = '0;
  logic       lsb_first = 1'b0;
  logic       bit_out, bit_valid, busy;
  int pass_cnt = 0;
  int tot_cnt = 0;

  serial_bit_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div       (div),
    .lsb_first (lsb_first),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tot_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready c=%0d got=%b exp=1", i, in_ready); else pass_cnt++;
      tot_cnt++; if (bit_out !== 1'b0) $display("FAIL reset_bit_out c=%0d got=%b exp=0", i, bit_out); else pass_cnt++;
      tot_cnt++; if (bit_valid !== 1'b0) $display("FAIL reset_bit_valid c=%0d got=%b exp=0", i, bit_valid); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy c=%0d got=%b exp=0", i, busy); else pass_cnt++;
    end
  endtask

  task automatic test_div0_msb();
    logic [7:0] w = 8'hDB;
    in_data = w; div = 8'd0; lsb_first = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tot_cnt++; if (busy !== 1'b1) $display("FAIL div0_busy_after_accept got=%b exp=1", busy); else pass_cnt++;
    tot_cnt++; if (bit_valid !== 1'b0) $display("FAIL div0_no_strobe_at_accept got=%b exp=0", bit_valid); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      step();
      tot_cnt++; if (bit_valid !== 1'b1) $display("FAIL div0_valid i=%0d got=%b exp=1", i, bit_valid); else pass_cnt++;
      tot_cnt++; if (bit_out !== w[7-i]) $display("FAIL div0_bit i=%0d got=%b exp=%b", i, bit_out, w[7-i]); else pass_cnt++;
    end
    tot_cnt++; if (busy !== 1'b0) $display("FAIL div0_busy_end got=%b exp=0", busy); else pass_cnt++;
    step();
    tot_cnt++; if (bit_valid !== 1'b0) $display("FAIL div0_valid_idle got=%b exp=0", bit_valid); else pass_cnt++;
    tot_cnt++; if (bit_out !== 1'b1) $display("FAIL div0_bit_hold got=%b exp=1", bit_out); else pass_cnt++;
  endtask

  task automatic test_div2_lsb();
    logic [7:0] w = 8'hDB;
    logic exp_v, exp_out, exp_busy;
    exp_out = 1'b1;
    in_data = w; div = 8'd2; lsb_first = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_v = (k % 3 == 0);
      if (exp_v) exp_out = w[k/3-1];
      exp_busy = (k < 24);
      tot_cnt++; if (bit_valid !== exp_v) $display("FAIL div2_valid k=%0d got=%b exp=%b", k, bit_valid, exp_v); else pass_cnt++;
      tot_cnt++; if (bit_out !== exp_out) $display("FAIL div2_bit k=%0d got=%b exp=%b", k, bit_out, exp_out); else pass_cnt++;
      tot_cnt++; if (busy !== exp_busy) $display("FAIL div2_busy k=%0d got=%b exp=%b", k, busy, exp_busy); else pass_cnt++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream = 16'b0001101101100000;
    logic [15:0] got = '0;
    logic exp_rdy, exp_busy;
    in_data = 8'h1B; div = 8'd0; lsb_first = 1'b0; in_valid = 1'b1;
    step();
    in_data = 8'h60;
    tot_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_k0 got=%b exp=0", in_ready); else pass_cnt++;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 8) in_valid = 1'b0;
      got[16-k] = bit_out;
      exp_rdy = (k == 7) || (k >= 15);
      exp_busy = (k < 16);
      tot_cnt++; if (bit_valid !== 1'b1) $display("FAIL b2b_valid k=%0d got=%b exp=1", k, bit_valid); else pass_cnt++;
      tot_cnt++; if (bit_out !== stream[16-k]) $display("FAIL b2b_bit k=%0d got=%b exp=%b", k, bit_out, stream[16-k]); else pass_cnt++;
      tot_cnt++; if (in_ready !== exp_rdy) $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy); else pass_cnt++;
      tot_cnt++; if (busy !== exp_busy) $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, exp_busy); else pass_cnt++;
    end
    tot_cnt++; if (got[9:5] !== 5'b11011) $display("FAIL b2b_boundary_11011 got=%b exp=11011", got[9:5]); else pass_cnt++;
    step();
    tot_cnt++; if (bit_valid !== 1'b0) $display("FAIL b2b_valid_after got=%b exp=0", bit_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    in_data = 8'hFF; div = 8'd0; lsb_first = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    tot_cnt++; if (bit_out !== 1'b1) $display("FAIL rst_mid_pre_bit got=%b exp=1", bit_out); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    tot_cnt++; if (bit_out !== 1'b0) $display("FAIL rst_mid_bit_out got=%b exp=0", bit_out); else pass_cnt++;
    tot_cnt++; if (bit_valid !== 1'b0) $display("FAIL rst_mid_bit_valid got=%b exp=0", bit_valid); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else pass_cnt++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tot_cnt++; if (bit_valid !== 1'b0) $display("FAIL rst_post_valid c=%0d got=%b exp=0", i, bit_valid); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL rst_post_busy c=%0d got=%b exp=0", i, busy); else pass_cnt++;
      tot_cnt++; if (bit_out !== 1'b0) $display("FAIL rst_post_bit c=%0d got=%b exp=0", i, bit_out); else pass_cnt++;
    end
    in_data = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      tot_cnt++; if (bit_valid !== 1'b1) $display("FAIL rst_zero_valid i=%0d got=%b exp=1", i, bit_valid); else pass_cnt++;
      tot_cnt++; if (bit_out !== 1'b0) $display("FAIL rst_zero_bit i=%0d got=%b exp=0", i, bit_out); else pass_cnt++;
    end
    step();
  endtask

  task automatic test_mid_word_changes();
    logic [7:0] w1 = 8'hA6;
    logic [7:0] w2 = 8'h3C;
    logic exp_v, exp_out, exp_rdy, exp_busy;
    exp_out = 1'b0;
    in_data = w1; div = 8'd0; lsb_first = 1'b0; in_valid = 1'b1;
    step();
    in_data = w2; div = 8'd5; lsb_first = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      step();
      if (k == 8) begin
        in_valid = 1'b0; div = 8'd0; lsb_first = 1'b0; in_data = 8'hFF;
      end
      exp_v = (k <= 8) ? 1'b1 : ((k - 8) % 6 == 0);
      if (exp_v) exp_out = (k <= 8) ? w1[8-k] : w2[(k-8)/6-1];
      exp_rdy = (k == 7) || (k >= 55);
      exp_busy = (k < 56);
      tot_cnt++; if (bit_valid !== exp_v) $display("FAIL mid_valid k=%0d got=%b exp=%b", k, bit_valid, exp_v); else pass_cnt++;
      tot_cnt++; if (bit_out !== exp_out) $display("FAIL mid_bit k=%0d got=%b exp=%b", k, bit_out, exp_out); else pass_cnt++;
      tot_cnt++; if (in_ready !== exp_rdy) $display("FAIL mid_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy); else pass_cnt++;
      tot_cnt++; if (busy !== exp_busy) $display("FAIL mid_busy k=%0d got=%b exp=%b", k, busy, exp_busy); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_div0_msb();
    test_div2_lsb();
    test_back_to_back();
    test_reset_mid_word();
    test_mid_word_changes();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
